// File: rtl/v2x_sha_arbiter_pkg.sv
// Shared types and SHA register map for the SHA-256 port arbiter.
// Imported by the arbiter top and its testbench.
package v2x_sha_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   localparam logic [7:0] SHA_ADDR_STATUS  = 8'h09;
   localparam logic [7:0] SHA_ADDR_DIGEST0 = 8'h20;

   localparam int OWNER_W = 3;

endpackage

// File: rtl/v2x_sha_arbiter_rr_picker.sv
// Round-robin picker: first eligible requester searching upward
// from a start index, wrapping at NUM_REQ.
module v2x_rr_picker #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_mask,
   input  logic [2:0]         i_start,
   output logic [NUM_REQ-1:0] o_pick,
   output logic [2:0]         o_idx,
   output logic               o_valid
);

   logic [NUM_REQ-1:0] elig;
   int                 idx;

   assign elig = i_req & ~i_mask;

   always_comb begin
      o_pick  = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(i_start) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!o_valid && elig[idx]) begin
            o_valid     = 1'b1;
            o_pick[idx] = 1'b1;
            o_idx       = 3'(idx);
         end
      end
   end

endmodule

// File: rtl/v2x_sha_arbiter.sv
// Shares the SHA-256 register port among requesters with round-robin
// lock ownership, a dead cycle between owners and an idle-owner watchdog.
module v2x_sha_arbiter
   import v2x_sha_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 13
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic [NUM_REQ-1:0]    i_req,
   output logic [NUM_REQ-1:0]    o_grant,
   input  logic [NUM_REQ-1:0]    i_req_cs,
   input  logic [NUM_REQ-1:0]    i_req_we,
   input  logic [NUM_REQ*8-1:0]  i_req_address,
   input  logic [NUM_REQ*32-1:0] i_req_write_data,
   output logic [31:0]           o_req_read_data,
   output logic [NUM_REQ-1:0]    o_req_error,
   output logic                  o_sha_cs,
   output logic                  o_sha_we,
   output logic [7:0]            o_sha_address,
   output logic [31:0]           o_sha_write_data,
   input  logic [31:0]           i_sha_read_data,
   input  logic                  i_sha_error,
   output logic                  o_busy,
   output logic [OWNER_W-1:0]    o_owner,
   output logic                  o_timeout_pulse,
   output logic [NUM_REQ-1:0]    o_timeout_flags
);

   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [2:0]       LAST_IDX = 3'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [2:0]         owner_q, owner_d;
   logic [2:0]         rr_q, rr_d;
   logic [CNT_W-1:0]   wdog_q, wdog_d;
   logic [NUM_REQ-1:0] mask_q, mask_d;
   logic [NUM_REQ-1:0] flags_q, flags_d;
   logic               pulse_q, pulse_d;

   logic [NUM_REQ-1:0] pick;
   logic [2:0]         pick_idx;
   logic               pick_valid;
   logic               owner_req;

   v2x_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .i_req   (i_req),
      .i_mask  (mask_q),
      .i_start (rr_q),
      .o_pick  (pick),
      .o_idx   (pick_idx),
      .o_valid (pick_valid)
   );

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         wdog_q  <= '0;
         mask_q  <= '0;
         flags_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         wdog_q  <= wdog_d;
         mask_q  <= mask_d;
         flags_q <= flags_d;
         pulse_q <= pulse_d;
      end
   end

   assign owner_req = |(i_req & grant_q);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      wdog_d  = wdog_q;
      mask_d  = mask_q & i_req;
      flags_d = flags_q;
      pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_RELEASE: begin
            if (pick_valid) begin
               grant_d = pick;
               owner_d = pick_idx;
               rr_d    = (pick_idx == LAST_IDX) ? 3'd0 : pick_idx + 3'd1;
               wdog_d  = '0;
               state_d = ST_GRANT;
            end else begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!owner_req) begin
               grant_d = '0;
               wdog_d  = '0;
               state_d = ST_RELEASE;
            end else if (o_sha_cs) begin
               wdog_d = '0;
            end else if (wdog_q == WD_LAST) begin
               // revoke a hung owner; it must drop req before regrant
               grant_d = '0;
               wdog_d  = '0;
               pulse_d = 1'b1;
               flags_d = flags_q | grant_q;
               mask_d  = mask_d | grant_q;
               state_d = ST_RELEASE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // grant is zero outside GRANT, so the mux idles the core bus there
   always_comb begin
      o_sha_cs         = 1'b0;
      o_sha_we         = 1'b0;
      o_sha_address    = '0;
      o_sha_write_data = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
         if (grant_q[n]) begin
            o_sha_cs         = o_sha_cs | i_req_cs[n];
            o_sha_we         = o_sha_we | i_req_we[n];
            o_sha_address    = o_sha_address | i_req_address[8*n +: 8];
            o_sha_write_data = o_sha_write_data | i_req_write_data[32*n +: 32];
         end
      end
   end

   assign o_grant         = grant_q;
   assign o_owner         = owner_q;
   assign o_busy          = (state_q != ST_IDLE);
   assign o_timeout_pulse = pulse_q;
   assign o_timeout_flags = flags_q;
   assign o_req_read_data = i_sha_read_data;
   assign o_req_error     = {NUM_REQ{i_sha_error}} & grant_q;

endmodule

// File: tb/tb_v2x_sha_arbiter.sv
// Directed bench for the SHA port arbiter: grant order, dead cycle,
// watchdog revoke, data routing, non-owner isolation and reset.
module tb_v2x_sha_arbiter;
   import v2x_sha_arbiter_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    cs;
   logic [NUM_REQ-1:0]    we;
   logic [NUM_REQ*8-1:0]  addr;
   logic [NUM_REQ*32-1:0] wdata;
   logic [31:0]           rdata;
   logic [NUM_REQ-1:0]    req_err;
   logic                  sha_cs;
   logic                  sha_we;
   logic [7:0]            sha_addr;
   logic [31:0]           sha_wdata;
   logic [31:0]           sha_rdata;
   logic                  sha_err;
   logic                  busy;
   logic [2:0]            owner;
   logic                  tpulse;
   logic [NUM_REQ-1:0]    tflags;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   v2x_sha_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_sys_clk        (clk),
      .i_sys_rst        (rst),
      .i_req            (req),
      .o_grant          (grant),
      .i_req_cs         (cs),
      .i_req_we         (we),
      .i_req_address    (addr),
      .i_req_write_data (wdata),
      .o_req_read_data  (rdata),
      .o_req_error      (req_err),
      .o_sha_cs         (sha_cs),
      .o_sha_we         (sha_we),
      .o_sha_address    (sha_addr),
      .o_sha_write_data (sha_wdata),
      .i_sha_read_data  (sha_rdata),
      .i_sha_error      (sha_err),
      .o_busy           (busy),
      .o_owner          (owner),
      .o_timeout_pulse  (tpulse),
      .o_timeout_flags  (tflags)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      cs        = '0;
      we        = '0;
      addr      = '0;
      wdata     = '0;
      sha_rdata = '0;
      sha_err   = 1'b0;
      step(2);
      chk("rst_grant", grant, 0);
      chk("rst_owner", owner, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", tflags, 0);
      chk("rst_pulse", tpulse, 0);
      chk("rst_cs", sha_cs, 0);
      rst = 1'b0;

      // 1: single requester write mirrors onto core bus
      req   = 2'b01;
      cs    = 2'b01;
      we    = 2'b01;
      addr  = {8'h00, 8'h10};
      wdata = {32'h0, 32'h61620000};
      step();
      chk("t1_grant", grant, 2'b01);
      chk("t1_cs", sha_cs, 1);
      chk("t1_we", sha_we, 1);
      chk("t1_addr", sha_addr, 8'h10);
      chk("t1_wdata", sha_wdata, 32'h61620000);
      chk("t1_busy", busy, 1);
      req = '0;
      step();
      chk("t1_rel_grant", grant, 0);
      chk("t1_rel_cs", sha_cs, 0);
      cs = '0;
      we = '0;
      step();
      chk("t1_idle_busy", busy, 0);

      // 2: simultaneous requests after reset, dead cycle, round robin
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 2'b11;
      step();
      chk("t2_first", grant, 2'b01);
      req = 2'b10;
      cs  = 2'b10;
      step();
      chk("t2_dead_grant", grant, 0);
      chk("t2_dead_cs", sha_cs, 0);
      chk("t2_dead_busy", busy, 1);
      step();
      chk("t2_second", grant, 2'b10);
      chk("t2_owner", owner, 1);
      chk("t2_owner_cs", sha_cs, 1);
      req = '0;
      cs  = '0;
      step(2);
      chk("t2_idle", busy, 0);
      req = 2'b11;
      step();
      chk("t2_rr", grant, 2'b01);

      // 3: hung owner 1 revoked after TIMEOUT idle cycles
      req = 2'b10;
      step(2);
      chk("t3_grant", grant, 2'b10);
      step(TIMEOUT - 1);
      chk("t3_hold", grant, 2'b10);
      chk("t3_nopulse", tpulse, 0);
      step();
      chk("t3_revoked", grant, 0);
      chk("t3_pulse", tpulse, 1);
      chk("t3_flags", tflags, 2'b10);
      step();
      chk("t3_pulse_1cyc", tpulse, 0);
      step(2);
      chk("t3_masked", grant, 0);
      req = '0;
      step();
      req = 2'b10;
      step();
      chk("t3_regrant", grant, 2'b10);
      req = '0;
      step(2);

      // 4: status poll returns data and error to owner only
      req  = 2'b01;
      cs   = 2'b01;
      we   = 2'b00;
      addr = {8'h00, SHA_ADDR_STATUS};
      step();
      chk("t4_grant", grant, 2'b01);
      sha_rdata = 32'h3;
      sha_err   = 1'b1;
      #1;
      chk("t4_rdata", rdata, 32'h3);
      chk("t4_err", req_err, 2'b01);
      chk("t4_addr", sha_addr, 8'h09);
      sha_err = 1'b0;

      // 5: non-owner activity never reaches the core
      req   = 2'b11;
      cs    = 2'b10;
      we    = 2'b10;
      addr  = {SHA_ADDR_DIGEST0, SHA_ADDR_STATUS};
      wdata = {32'hDEADBEEF, 32'h0};
      #1;
      chk("t5_cs_iso", sha_cs, 0);
      chk("t5_we_iso", sha_we, 0);
      step();
      chk("t5_grant", grant, 2'b01);
      cs = 2'b11;
      #1;
      chk("t5_cs_own", sha_cs, 1);
      chk("t5_addr", sha_addr, 8'h09);
      chk("t5_wdata", sha_wdata, 32'h0);
      step();

      // owner drops req on the expiry cycle: plain release
      cs  = '0;
      we  = '0;
      req = 2'b01;
      step(TIMEOUT - 1);
      chk("wd_hold", grant, 2'b01);
      req = '0;
      step();
      chk("wd_rel_grant", grant, 0);
      chk("wd_rel_pulse", tpulse, 0);
      chk("wd_rel_flags", tflags, 2'b10);
      step();

      // 6: reset during an owner write burst
      req   = 2'b01;
      cs    = 2'b01;
      we    = 2'b01;
      addr  = {8'h00, 8'h10};
      wdata = {32'h0, 32'h00000001};
      step(2);
      chk("t6_burst_cs", sha_cs, 1);
      rst = 1'b1;
      step();
      chk("t6_grant", grant, 0);
      chk("t6_cs", sha_cs, 0);
      chk("t6_flags", tflags, 0);
      chk("t6_busy", busy, 0);
      rst = 1'b0;
      req = '0;
      step();
      chk("t6_after_cs", sha_cs, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
